// File: rtl/board_io_ctrl_if.sv
// Pin-side and core-side signal bundle of the board I/O front-end.
// master: board/stimulus side driving raw pins; slave: board_io_ctrl itself.
interface board_io_ctrl_if #(
    parameter int unsigned SW_W  = 16,
    parameter int unsigned NBTN  = 2,
    parameter int unsigned CNT_W = 32
);
    logic [SW_W-1:0]  sw_raw;
    logic [NBTN-1:0]  btn_raw;
    logic [SW_W-1:0]  sw_clean;
    logic [NBTN-1:0]  btn_level;
    logic [NBTN-1:0]  btn_press;
    logic             en0;
    logic             running;
    logic [CNT_W-1:0] en_count;

    modport master (
        output sw_raw, btn_raw,
        input  sw_clean, btn_level, btn_press, en0, running, en_count
    );

    modport slave (
        input  sw_raw, btn_raw,
        output sw_clean, btn_level, btn_press, en0, running, en_count
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O front-end: synchronise/debounce buttons and switches, derive press
// pulses, and run the run/halt/single-step FSM that gates the processor enable.
module board_io_ctrl #(
    parameter int unsigned SW_W        = 16,
    parameter int unsigned NBTN        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned SW_DEBOUNCE = 1,
    parameter int unsigned CNT_W       = 32
) (
    input logic clk0,
    input logic rst0,
    board_io_ctrl_if.slave io
);
    localparam int unsigned NIN  = SW_W + NBTN;
    localparam int unsigned NDEB = (SW_DEBOUNCE != 0) ? NIN : NBTN;
    localparam int unsigned CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0]                  s;
    logic [NDEB-1:0]                 deb_q;
    logic [NDEB-1:0][CW-1:0]         cnt_q;
    logic [NBTN-1:0]                 btn_lvl;
    logic [NBTN-1:0]                 lvl_d;
    logic [NBTN-1:0]                 press_q;
    state_t                          state_q, state_d;
    logic                            en;
    logic                            run;
    logic [CNT_W-1:0]                count_q;

    // Buttons occupy the low bits so they are always inside the debounced range.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {io.sw_raw, io.btn_raw}};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NDEB; i++) begin
                if (s[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CMAX) begin
                    deb_q[i] <= s[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn_lvl = deb_q[NBTN-1:0];

    if (SW_DEBOUNCE != 0) begin : g_sw_deb
        assign io.sw_clean = deb_q[NIN-1:NBTN];
    end else begin : g_sw_sync
        assign io.sw_clean = s[NIN-1:NBTN];
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            lvl_d   <= '0;
            press_q <= '0;
        end else begin
            lvl_d   <= btn_lvl;
            press_q <= btn_lvl & ~lvl_d;
        end
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state_q <= HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // Run/halt toggle takes priority over a step press arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        en      = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            HALT: begin
                if (press_q[0]) begin
                    state_d = RUN;
                end else if (press_q[1]) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                state_d = HALT;
                en      = 1'b1;
            end
            RUN: begin
                if (press_q[0]) begin
                    state_d = HALT;
                end
                en  = 1'b1;
                run = 1'b1;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign io.btn_level = btn_lvl;
    assign io.btn_press = press_q;
    assign io.en0       = en;
    assign io.running   = run;
    assign io.en_count  = count_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// Randomised and directed bench for board_io_ctrl against a window-based
// reference model of the debounce, press and run/halt/step rules.
module tb_board_io_ctrl;
    localparam int unsigned SW_W  = 16;
    localparam int unsigned NBTN  = 3;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned DEB   = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NIN   = SW_W + NBTN;
    localparam int unsigned OBS_W = 2*NBTN + 2 + CNT_W + 2*SW_W;

    logic            clk0 = 1'b0;
    logic            rst0 = 1'b1;
    logic [SW_W-1:0] sw   = '0;
    logic [NBTN-1:0] btn  = '0;

    int checks = 0;
    int errors = 0;

    board_io_ctrl_if #(.SW_W(SW_W), .NBTN(NBTN), .CNT_W(CNT_W)) ifa ();
    board_io_ctrl_if #(.SW_W(SW_W), .NBTN(NBTN), .CNT_W(CNT_W)) ifb ();

    assign ifa.sw_raw  = sw;
    assign ifa.btn_raw = btn;
    assign ifb.sw_raw  = sw;
    assign ifb.btn_raw = btn;

    board_io_ctrl #(
        .SW_W(SW_W), .NBTN(NBTN), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB),
        .SW_DEBOUNCE(1), .CNT_W(CNT_W)
    ) dut (
        .clk0(clk0), .rst0(rst0), .io(ifa)
    );

    board_io_ctrl #(
        .SW_W(SW_W), .NBTN(NBTN), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB),
        .SW_DEBOUNCE(0), .CNT_W(CNT_W)
    ) dut_nd (
        .clk0(clk0), .rst0(rst0), .io(ifb)
    );

    always #5 clk0 = ~clk0;

    // Reference model: a level flips once the synchronised pin has disagreed with
    // it for DEB consecutive samples; samp holds the last SYNC+DEB pin samples.
    logic [NIN-1:0]   samp [$];
    logic [NIN-1:0]   m_lvl, m_lvl_d;
    logic [NBTN-1:0]  m_press;
    logic             m_run, m_step;
    logic [CNT_W-1:0] m_cnt;
    logic [SW_W-1:0]  m_sw_nd;
    bit               m_flip;

    always @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            samp.delete();
            for (int i = 0; i < SYNC + DEB; i++) samp.push_back('0);
            m_lvl = '0; m_lvl_d = '0; m_press = '0;
            m_run = 1'b0; m_step = 1'b0; m_cnt = '0; m_sw_nd = '0;
        end else begin
            if (m_run || m_step) m_cnt = m_cnt + 1'b1;
            if (m_step) m_step = 1'b0;
            else if (m_run) begin
                if (m_press[0]) m_run = 1'b0;
            end else if (m_press[0]) m_run = 1'b1;
            else if (m_press[1]) m_step = 1'b1;
            m_press = m_lvl[NBTN-1:0] & ~m_lvl_d[NBTN-1:0];
            m_lvl_d = m_lvl;
            samp.push_back({sw, btn});
            void'(samp.pop_front());
            for (int b = 0; b < NIN; b++) begin
                m_flip = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (samp[j][b] == m_lvl[b]) m_flip = 1'b0;
                if (m_flip) m_lvl[b] = ~m_lvl[b];
            end
            m_sw_nd = samp[DEB][NIN-1:NBTN];
        end
    end

    logic [OBS_W-1:0] dut_obs, mdl_obs;
    assign dut_obs = {ifa.btn_level, ifa.btn_press, ifa.en0, ifa.running,
                      ifa.en_count, ifa.sw_clean, ifb.sw_clean};
    assign mdl_obs = {m_lvl[NBTN-1:0], m_press, m_run | m_step, m_run,
                      m_cnt, m_lvl[NIN-1:NBTN], m_sw_nd};

    task automatic test_reset;
        rst0 = 1'b1; sw = '0; btn = '0;
        repeat (3) @(negedge clk0);
        checks++;
        if (dut_obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", dut_obs);
        end
        rst0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk0);
            checks++;
            if (dut_obs !== mdl_obs || ifa.en0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_release got %h want %h", dut_obs, mdl_obs);
            end
        end
    endtask

    task automatic test_debounce;
        int rise_at = -1;
        int press_at = -1;
        int npress = 0;
        btn[1] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk0);
            if (c == 3) btn[1] = 1'b0;
            checks++;
            if (ifa.btn_level[1] !== 1'b0 || ifa.btn_press[1] !== 1'b0 || dut_obs !== mdl_obs) begin
                errors++;
                $display("FAIL glitch_suppress got lvl=%b prs=%b obs=%h want 0 0 %h",
                         ifa.btn_level[1], ifa.btn_press[1], dut_obs, mdl_obs);
            end
        end
        btn[1] = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk0);
            if (c == 10) btn[1] = 1'b0;
            if (ifa.btn_level[1] === 1'b1 && rise_at < 0) rise_at = c;
            if (ifa.btn_press[1] === 1'b1) begin
                npress++;
                if (press_at < 0) press_at = c;
            end
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++;
                $display("FAIL debounce_model c=%0d got %h want %h", c, dut_obs, mdl_obs);
            end
        end
        checks++;
        if (rise_at != 6 || press_at != 7 || npress != 1) begin
            errors++;
            $display("FAIL debounce_latency got rise=%0d press=%0d n=%0d want 6 7 1",
                     rise_at, press_at, npress);
        end
    endtask

    task automatic test_step;
        logic [CNT_W-1:0] c0;
        int en_cycles = 0;
        int en_at = -1;
        bit saw_run = 1'b0;
        c0 = m_cnt;
        btn[1] = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk0);
            if (c == 8) btn[1] = 1'b0;
            if (ifa.en0 === 1'b1) begin
                en_cycles++;
                if (en_at < 0) en_at = c;
            end
            if (ifa.running !== 1'b0) saw_run = 1'b1;
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++;
                $display("FAIL step_model c=%0d got %h want %h", c, dut_obs, mdl_obs);
            end
        end
        checks++;
        if (en_cycles != 1 || en_at != 8 || saw_run || ifa.en_count !== c0 + 1'b1) begin
            errors++;
            $display("FAIL step_once got en=%0d at=%0d run=%0b cnt=%0d want 1 8 0 %0d",
                     en_cycles, en_at, saw_run, ifa.en_count, c0 + 1'b1);
        end
    endtask

    task automatic press_release(input int idx, input int hold, input int settle);
        btn[idx] = 1'b1;
        for (int c = 1; c <= hold + settle; c++) begin
            @(negedge clk0);
            if (c == hold) btn[idx] = 1'b0;
        end
    endtask

    task automatic test_run;
        logic [CNT_W-1:0] cstart;
        int n_en = 0;
        int run_at = -1;
        cstart = m_cnt;
        btn[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk0);
            if (c == 8) btn[0] = 1'b0;
            if (m_run | m_step) n_en++;
            if (ifa.running === 1'b1 && run_at < 0) run_at = c;
        end
        checks++;
        if (run_at != 8) begin
            errors++;
            $display("FAIL run_start got %0d want 8", run_at);
        end
        btn[1] = 1'b1;
        for (int c = 1; c <= 8 + int'($urandom_range(18, 30)); c++) begin
            @(negedge clk0);
            if (c == 8) btn[1] = 1'b0;
            if (m_run | m_step) n_en++;
            checks++;
            if (ifa.running !== 1'b1 || ifa.en0 !== 1'b1 || dut_obs !== mdl_obs) begin
                errors++;
                $display("FAIL run_hold got run=%b en=%b obs=%h want 1 1 %h",
                         ifa.running, ifa.en0, dut_obs, mdl_obs);
            end
        end
        btn[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk0);
            if (c == 8) btn[0] = 1'b0;
            if (m_run | m_step) n_en++;
        end
        checks++;
        if (ifa.running !== 1'b0 || ifa.en0 !== 1'b0 ||
            ifa.en_count !== CNT_W'(int'(cstart) + n_en)) begin
            errors++;
            $display("FAIL run_stop got run=%b en=%b cnt=%0d want 0 0 %0d",
                     ifa.running, ifa.en0, ifa.en_count, CNT_W'(int'(cstart) + n_en));
        end
    endtask

    task automatic test_simul;
        logic [CNT_W-1:0] prev = '0;
        bit prev_en = 1'b0;
        bit first = 1'b1;
        bit saw_wrap = 1'b0;
        btn[1:0] = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk0);
            if (c == 8) btn[1:0] = 2'b00;
            if (ifa.en0 === 1'b1 && first) begin
                first = 1'b0;
                checks++;
                if (ifa.running !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_no_step got running=%b want 1", ifa.running);
                end
            end
            if (prev_en) begin
                checks++;
                if (ifa.en_count !== prev + 1'b1) begin
                    errors++;
                    $display("FAIL count_incr got %0d want %0d", ifa.en_count, prev + 1'b1);
                end
                if (prev == '1 && ifa.en_count === '0) saw_wrap = 1'b1;
            end
            prev = ifa.en_count;
            prev_en = (ifa.en0 === 1'b1);
        end
        checks++;
        if (!saw_wrap || first) begin
            errors++;
            $display("FAIL count_wrap got wrap=%0b en_seen=%0b want 1 1", saw_wrap, !first);
        end
        press_release(0, 8, 14);
        checks++;
        if (ifa.running !== 1'b0 || dut_obs !== mdl_obs) begin
            errors++;
            $display("FAIL simul_stop got %h want %h", dut_obs, mdl_obs);
        end
    endtask

    task automatic test_reset_midrun;
        bit hit = 1'b0;
        btn[0] = 1'b1;
        for (int c = 1; c <= 60 && !hit; c++) begin
            @(negedge clk0);
            if (c == 8) btn[0] = 1'b0;
            if (ifa.running === 1'b1 && ifa.en_count === 4'd5) hit = 1'b1;
        end
        btn = '0;
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midrun_reach got count=%0d want 5", ifa.en_count);
        end
        #2 rst0 = 1'b1;
        #1;
        checks++;
        if (dut_obs !== '0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", dut_obs);
        end
        @(negedge clk0);
        rst0 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk0);
            checks++;
            if (ifa.en0 !== 1'b0 || dut_obs !== mdl_obs) begin
                errors++;
                $display("FAIL post_reset got en=%b obs=%h want 0 %h", ifa.en0, dut_obs, mdl_obs);
            end
        end
    endtask

    task automatic test_switch;
        int at_deb = -1;
        int at_nd = -1;
        sw = 16'hA5A5;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk0);
            if (ifa.sw_clean === 16'hA5A5 && at_deb < 0) at_deb = c;
            if (ifb.sw_clean === 16'hA5A5 && at_nd < 0) at_nd = c;
        end
        checks++;
        if (at_deb != 6 || at_nd != 2) begin
            errors++;
            $display("FAIL switch_latency got deb=%0d sync=%0d want 6 2", at_deb, at_nd);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            btn = NBTN'($urandom);
            if ($urandom_range(0, 3) == 0) sw = SW_W'($urandom);
            for (int h = $urandom_range(1, 9); h > 0; h--) begin
                @(negedge clk0);
                checks++;
                if (dut_obs !== mdl_obs) begin
                    errors++;
                    $display("FAIL random_model n=%0d got %h want %h", n, dut_obs, mdl_obs);
                end
            end
        end
        btn = '0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_step();
        test_run();
        test_simul();
        test_reset_midrun();
        test_switch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
